mem_stage_sram_ctrl: RTL

- MEM-stage consumer of the EXE/MEM pipeline register outputs: mem_r_en, mem_w_en, alu_result (address) and st_val.
- Performs 32-bit loads and stores against an external 16-bit-wide SRAM, using two half-word phases per access.
- Drives ready low while an access is in flight; the hazard/freeze logic uses ready to stall all upstream pipeline registers.
- Returns load data to the MEM/WB register on read_data.

---
 rtl/mem_stage_sram_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: performs 32-bit loads/stores on a 16-bit SRAM in two
// half-word phases, holding ready low so the pipeline freezes meanwhile.
module mem_stage_sram_ctrl #(
   parameter int ADDR_OFFSET   = 1024,
   parameter int SRAM_AW       = 18,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        alu_result,
   input  logic [31:0]        st_val,
   output logic               ready,
   output logic [31:0]        read_data,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SRAM_AW-1:0] base_q, base_d;
   logic [31:0]        st_val_q, st_val_d;
   logic [31:0]        read_data_q, read_data_d;
   logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]        sram_dq_out_q, sram_dq_out_d;
   logic               sram_dq_oe_q, sram_dq_oe_d;
   logic               sram_we_n_q, sram_we_n_d;

   logic               req;
   logic               last;
   logic [31:0]        off;
   logic [SRAM_AW-1:0] base_now;
   logic               unused_off_bits;

   assign req             = mem_r_en | mem_w_en;
   assign last            = (cnt_q == CW'(ACCESS_CYCLES - 1));
   assign off             = alu_result - 32'(ADDR_OFFSET);
   assign base_now        = {off[SRAM_AW:2], 1'b0};
   assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

   assign ready = !(((state_q == IDLE) && req) || (state_q == WR_LO) || (state_q == WR_HI) ||
                    (state_q == RD_LO) || (state_q == RD_HI));

   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = sram_dq_out_q;
   assign sram_dq_oe  = sram_dq_oe_q;
   assign sram_we_n   = sram_we_n_q;

   // Pin values for the next phase are loaded on the edge that enters it, so
   // they stay stable for the whole phase.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      base_d        = base_q;
      st_val_d      = st_val_q;
      read_data_d   = read_data_q;
      sram_addr_d   = sram_addr_q;
      sram_dq_out_d = sram_dq_out_q;
      sram_dq_oe_d  = sram_dq_oe_q;
      sram_we_n_d   = sram_we_n_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req) begin
               base_d      = base_now;
               st_val_d    = st_val;
               sram_addr_d = base_now;
               if (mem_w_en) begin
                  state_d       = WR_LO;
                  sram_dq_out_d = st_val[15:0];
                  sram_we_n_d   = 1'b0;
                  sram_dq_oe_d  = 1'b1;
               end else begin
                  state_d      = RD_LO;
                  sram_we_n_d  = 1'b1;
                  sram_dq_oe_d = 1'b0;
               end
            end
         end
         WR_LO: begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d       = WR_HI;
               cnt_d         = '0;
               sram_addr_d   = base_q + SRAM_AW'(1);
               sram_dq_out_d = st_val_q[31:16];
            end
         end
         WR_HI: begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d      = DONE;
               cnt_d        = '0;
               sram_we_n_d  = 1'b1;
               sram_dq_oe_d = 1'b0;
            end
         end
         RD_LO: begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d           = RD_HI;
               cnt_d             = '0;
               read_data_d[15:0] = sram_dq_in;
               sram_addr_d       = base_q + SRAM_AW'(1);
            end
         end
         RD_HI: begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d            = DONE;
               cnt_d              = '0;
               read_data_d[31:16] = sram_dq_in;
               sram_we_n_d        = 1'b1;
               sram_dq_oe_d       = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d      = IDLE;
            cnt_d        = '0;
            sram_we_n_d  = 1'b1;
            sram_dq_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         base_q        <= '0;
         st_val_q      <= '0;
         read_data_q   <= '0;
         sram_addr_q   <= '0;
         sram_dq_out_q <= '0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         base_q        <= base_d;
         st_val_q      <= st_val_d;
         read_data_q   <= read_data_d;
         sram_addr_q   <= sram_addr_d;
         sram_dq_out_q <= sram_dq_out_d;
         sram_dq_oe_q  <= sram_dq_oe_d;
         sram_we_n_q   <= sram_we_n_d;
      end
   end

endmodule
